// File: rtl/xif_core_offload_pkg.sv
// Shared types and constants for the CORE-V-XIF core-side offload agent.
// The LFSR constants are only used when XIF_RESULT_BP_EN is defined.
package pa_rvfpm;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        COMMIT = 2'd2
    } xif_core_state_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting toward the MSB
    localparam logic [7:0] XIF_LFSR_SEED = 8'hA5;
    localparam logic [7:0] XIF_LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/xif_core_offload_id_tracker.sv
// Instruction ID allocation and outstanding-result bookkeeping for xif_core_offload.
// Counts outstanding IDs and flags results whose ID is not outstanding.
module xif_id_tracker #(
    parameter int X_ID_WIDTH = 4
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  i_issue_fire,
    input  logic                  i_set_en,
    input  logic                  i_res_fire,
    input  logic [X_ID_WIDTH-1:0] i_res_id,
    output logic [X_ID_WIDTH-1:0] o_next_id,
    output logic                  o_next_busy,
    output logic                  o_res_hit,
    output logic                  o_err,
    output logic [X_ID_WIDTH:0]   o_cnt
);

    localparam int N_IDS = 1 << X_ID_WIDTH;

    logic [X_ID_WIDTH-1:0] r_next_id;
    logic [N_IDS-1:0]      r_map;
    logic                  r_err;
    logic [X_ID_WIDTH:0]   r_cnt;

    logic [N_IDS-1:0]      w_map_nxt;
    logic [X_ID_WIDTH:0]   w_cnt_nxt;

    // The ID being issued is always r_next_id: it only advances on the issue handshake.
    always_comb begin
        w_map_nxt = r_map;
        if (i_res_fire && r_map[i_res_id])
            w_map_nxt[i_res_id] = 1'b0;
        if (i_set_en)
            w_map_nxt[r_next_id] = 1'b1;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 0; i < N_IDS; i++)
            w_cnt_nxt = w_cnt_nxt + {{X_ID_WIDTH{1'b0}}, w_map_nxt[i]};
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_next_id <= '0;
            r_map     <= '0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_map <= w_map_nxt;
            r_cnt <= w_cnt_nxt;
            if (i_issue_fire)
                r_next_id <= r_next_id + 1'b1;
            if (i_res_fire && !r_map[i_res_id])
                r_err <= 1'b1;
        end
    end

    assign o_next_id   = r_next_id;
    assign o_next_busy = r_map[r_next_id];
    assign o_res_hit   = r_map[i_res_id];
    assign o_err       = r_err;
    assign o_cnt       = r_cnt;

endmodule

// File: rtl/xif_core_offload.sv
// Core-side CORE-V-XIF agent: issues, commits and retires offloaded instructions.
// Optional macro XIF_RESULT_BP_EN: pseudo-random result backpressure from an LFSR.
//
// state  | meaning
// IDLE   | waiting for a source instruction whose ID slot is free
// ISSUE  | issue_valid held with stable fields until issue_ready
// COMMIT | one-cycle commit (kill if killed or rejected)
module xif_core_offload
    import pa_rvfpm::*;
#(
    parameter int XLEN       = 32,
    parameter int X_NUM_RS   = 3,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                       ck,
    input  logic                       rst_n,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    input  logic [31:0]                instr,
    input  logic [X_NUM_RS*XLEN-1:0]   instr_rs,
    input  logic                       instr_kill,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [31:0]                issue_instr,
    output logic [X_ID_WIDTH-1:0]      issue_id,
    output logic [X_NUM_RS*XLEN-1:0]   issue_rs,
    output logic [X_NUM_RS-1:0]        issue_rs_valid,
    input  logic                       issue_accept,
    input  logic                       issue_writeback,
    output logic                       commit_valid,
    output logic [X_ID_WIDTH-1:0]      commit_id,
    output logic                       commit_kill,
    input  logic                       result_valid,
    output logic                       result_ready,
    input  logic [X_ID_WIDTH-1:0]      result_id,
    input  logic [XLEN-1:0]            result_data,
    input  logic [4:0]                 result_rd,
    input  logic                       result_we,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [XLEN-1:0]            wb_data,
    output logic                       rejected,
    output logic                       err_unexpected_id,
    output logic [X_ID_WIDTH:0]        outstanding_cnt
);

    xif_core_state_t           r_state;
    logic                      r_run;
    logic [31:0]               r_instr;
    logic [X_NUM_RS*XLEN-1:0]  r_rs;
    logic                      r_kill;
    logic [X_ID_WIDTH-1:0]     r_id;
    logic                      r_issue_valid;
    logic                      r_commit_valid;
    logic                      r_commit_kill;
    logic                      r_rejected;
    logic                      r_wb_valid;
    logic [4:0]                r_wb_rd;
    logic [XLEN-1:0]           r_wb_data;

    logic                      w_instr_fire;
    logic                      w_issue_fire;
    logic                      w_set_en;
    logic                      w_res_fire;
    logic                      w_res_hit;
    logic                      w_next_busy;
    logic [X_ID_WIDTH-1:0]     w_next_id;
    logic                      w_result_ready;

    assign instr_ready  = r_run && (r_state == IDLE) && !w_next_busy;
    assign w_instr_fire = instr_valid && instr_ready;
    assign w_issue_fire = r_issue_valid && issue_ready;
    assign w_set_en     = w_issue_fire && issue_accept && issue_writeback && !r_kill;
    assign w_res_fire   = result_valid && w_result_ready;

`ifdef XIF_RESULT_BP_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n)
            r_lfsr <= XIF_LFSR_SEED;
        else
            r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & XIF_LFSR_TAPS)};
    end

    // Gated by r_run so result_ready is still low while in reset
    assign w_result_ready = r_run && r_lfsr[0];
`else
    assign w_result_ready = r_run;
`endif

    xif_id_tracker #(
        .X_ID_WIDTH (X_ID_WIDTH)
    ) u_id_tracker (
        .ck           (ck),
        .rst_n        (rst_n),
        .i_issue_fire (w_issue_fire),
        .i_set_en     (w_set_en),
        .i_res_fire   (w_res_fire),
        .i_res_id     (result_id),
        .o_next_id    (w_next_id),
        .o_next_busy  (w_next_busy),
        .o_res_hit    (w_res_hit),
        .o_err        (err_unexpected_id),
        .o_cnt        (outstanding_cnt)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_run          <= 1'b0;
            r_instr        <= '0;
            r_rs           <= '0;
            r_kill         <= 1'b0;
            r_id           <= '0;
            r_issue_valid  <= 1'b0;
            r_commit_valid <= 1'b0;
            r_commit_kill  <= 1'b0;
            r_rejected     <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
        end else begin
            r_run          <= 1'b1;
            r_commit_valid <= 1'b0;
            r_rejected     <= 1'b0;
            r_wb_valid     <= w_res_fire && w_res_hit && result_we;
            if (w_res_fire && w_res_hit && result_we) begin
                r_wb_rd   <= result_rd;
                r_wb_data <= result_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_instr_fire) begin
                        r_instr       <= instr;
                        r_rs          <= instr_rs;
                        r_kill        <= instr_kill;
                        r_id          <= w_next_id;
                        r_issue_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue_fire) begin
                        r_issue_valid  <= 1'b0;
                        r_commit_valid <= 1'b1;
                        // A rejected issue is still committed, as a kill
                        r_commit_kill  <= r_kill || !issue_accept;
                        r_rejected     <= !issue_accept;
                        r_state        <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign issue_valid    = r_issue_valid;
    assign issue_instr    = r_instr;
    assign issue_id       = r_id;
    assign issue_rs       = r_rs;
    assign issue_rs_valid = {X_NUM_RS{r_issue_valid}};
    assign commit_valid   = r_commit_valid;
    assign commit_id      = r_id;
    assign commit_kill    = r_commit_kill;
    assign result_ready   = w_result_ready;
    assign wb_valid       = r_wb_valid;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign rejected       = r_rejected;

endmodule
